// File: rtl/execute_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : execute_alu_arbiter
// Brief    : Round-robin share of one ALU between two execute requesters,
//            with a single registered, backpressured result slot.
// Revision : 1.0 - initial release
// ============================================================================
module execute_alu_arbiter #(
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [2:0]       req0_op,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [2:0]       req1_op,
    input  logic [TAG_W-1:0] req1_tag,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [2:0]       alu_op,
    input  logic [31:0]      alu_c,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic             res_src,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_err,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    localparam logic [2:0] c_OP_UNSUPPORTED = 3'b010;

    logic             r_res_valid;
    logic [31:0]      r_res_data;
    logic             r_res_src;
    logic [TAG_W-1:0] r_res_tag;
    logic             r_res_err;
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;
    logic             r_rr_last;

    logic             w_can_accept;
    logic             w_gnt_valid;
    logic             w_gnt_idx;
    logic [31:0]      w_a;
    logic [31:0]      w_b;
    logic [2:0]       w_op;
    logic [TAG_W-1:0] w_tag;

    // Reset gates acceptance so no handshake completes during the rst cycle.
    always_comb begin
        w_can_accept = (~r_res_valid | res_ready) & ~rst;
        w_gnt_valid  = w_can_accept & (req0_valid | req1_valid);
        if (req0_valid && req1_valid) begin
            w_gnt_idx = ~r_rr_last;
        end else begin
            w_gnt_idx = req1_valid;
        end
    end

    always_comb begin
        w_a   = w_gnt_idx ? req1_a   : req0_a;
        w_b   = w_gnt_idx ? req1_b   : req0_b;
        w_op  = w_gnt_idx ? req1_op  : req0_op;
        w_tag = w_gnt_idx ? req1_tag : req0_tag;
    end

    assign alu_a      = w_gnt_valid ? w_a  : 32'd0;
    assign alu_b      = w_gnt_valid ? w_b  : 32'd0;
    assign alu_op     = w_gnt_valid ? w_op : 3'd0;
    assign req0_ready = w_gnt_valid & ~w_gnt_idx;
    assign req1_ready = w_gnt_valid &  w_gnt_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_valid <= 1'b0;
            r_res_data  <= 32'd0;
            r_res_src   <= 1'b0;
            r_res_tag   <= '0;
            r_res_err   <= 1'b0;
            r_rr_last   <= 1'b1;
        end else if (w_gnt_valid) begin
            r_res_valid <= 1'b1;
            r_res_src   <= w_gnt_idx;
            r_res_tag   <= w_tag;
            r_rr_last   <= w_gnt_idx;
            if (w_op == c_OP_UNSUPPORTED) begin
                r_res_data <= 32'd0;
                r_res_err  <= 1'b1;
            end else begin
                r_res_data <= alu_c;
                r_res_err  <= 1'b0;
            end
        end else if (res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    // Grant counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (req0_ready && r_cnt0 != {CNT_W{1'b1}}) begin
                r_cnt0 <= r_cnt0 + 1'b1;
            end
            if (req1_ready && r_cnt1 != {CNT_W{1'b1}}) begin
                r_cnt1 <= r_cnt1 + 1'b1;
            end
        end
    end

    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_src   = r_res_src;
    assign res_tag   = r_res_tag;
    assign res_err   = r_res_err;
    assign cnt0      = r_cnt0;
    assign cnt1      = r_cnt1;

endmodule
`default_nettype wire
